// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding and flag bit positions.
package alu_pkg;

   localparam int DataWidth = 16;
   localparam int FlagWidth = 4;

   // Flag vector layout is {overflow, carry, negative, zero}
   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_C = 2;
   localparam int FLAG_V = 3;

   // Opcodes 5..7 are intentionally left unnamed; the core treats them as illegal
   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_MUL = 3'd2,
      OP_RR  = 3'd3,
      OP_RL  = 3'd4
   } alu_op_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU datapath: computes result, flags and illegal-op indication.
module alu_core
   import alu_pkg::*;
(
   input  logic [DataWidth-1:0] a,
   input  logic [DataWidth-1:0] b,
   input  logic [2:0]           alu_op,
   output logic [DataWidth-1:0] result,
   output logic [FlagWidth-1:0] flags,
   output logic                 illegal_op
);

   logic [DataWidth:0]     sumWide;
   logic [DataWidth:0]     diffWide;
   logic [2*DataWidth-1:0] prodWide;
   logic                   carryBit;
   logic                   overflowBit;
   alu_op_t                opSel;

   // Widened arithmetic so carry, borrow and the upper product half are directly visible
   assign sumWide  = {1'b0, a} + {1'b0, b};
   assign diffWide = {1'b0, a} - {1'b0, b};
   assign prodWide = {{DataWidth{1'b0}}, a} * {{DataWidth{1'b0}}, b};
   assign opSel    = alu_op_t'(alu_op);

   // Operation select; anything outside the named opcodes yields zero and raises illegal_op
   always_comb begin
      result      = '0;
      carryBit    = 1'b0;
      overflowBit = 1'b0;
      illegal_op  = 1'b0;
      case (opSel)
         OP_ADD: begin
            result      = sumWide[DataWidth-1:0];
            carryBit    = sumWide[DataWidth];
            overflowBit = (a[DataWidth-1] == b[DataWidth-1]) &&
                          (sumWide[DataWidth-1] != a[DataWidth-1]);
         end
         OP_SUB: begin
            result      = diffWide[DataWidth-1:0];
            carryBit    = diffWide[DataWidth];
            overflowBit = (a[DataWidth-1] != b[DataWidth-1]) &&
                          (diffWide[DataWidth-1] != a[DataWidth-1]);
         end
         OP_MUL: begin
            result   = prodWide[DataWidth-1:0];
            carryBit = |prodWide[2*DataWidth-1:DataWidth];
         end
         OP_RR: begin
            result   = {1'b0, b[DataWidth-1:1]};
            carryBit = b[0];
         end
         OP_RL: begin
            result   = {b[DataWidth-2:0], 1'b0};
            carryBit = b[DataWidth-1];
         end
         default: begin
            illegal_op = 1'b1;
         end
      endcase
   end

   // Assemble flags; zero and negative are derived from the result for every op
   always_comb begin
      flags         = '0;
      flags[FLAG_Z] = (result == '0);
      flags[FLAG_N] = result[DataWidth-1];
      flags[FLAG_C] = carryBit;
      flags[FLAG_V] = overflowBit;
   end

endmodule

// File: rtl/alu.sv
// ALU top: combinational core plus capture registers loaded by the en strobe.
module alu
   import alu_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DataWidth-1:0] a,
   input  logic [DataWidth-1:0] b,
   input  logic [2:0]           alu_op,
   input  logic                 en,
   output logic [DataWidth-1:0] result,
   output logic [FlagWidth-1:0] flags,
   output logic                 illegal_op,
   output logic [DataWidth-1:0] result_q,
   output logic [FlagWidth-1:0] flags_q,
   output logic                 valid_q
);

   logic [DataWidth-1:0] result_d;
   logic [FlagWidth-1:0] flags_d;

   alu_core u_core (
      .a          (a),
      .b          (b),
      .alu_op     (alu_op),
      .result     (result),
      .flags      (flags),
      .illegal_op (illegal_op)
   );

   // Next-state: load the live core outputs when strobed, otherwise hold
   always_comb begin
      result_d = result_q;
      flags_d  = flags_q;
      if (en) begin
         result_d = result;
         flags_d  = flags;
      end
   end

   // Capture registers; valid_q marks the cycle following a capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q <= '0;
         flags_q  <= '0;
         valid_q  <= 1'b0;
      end else begin
         result_q <= result_d;
         flags_q  <= flags_d;
         valid_q  <= en;
      end
   end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the ALU: combinational vectors plus register/reset behaviour.
module tb_alu;
   import alu_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [15:0] a;
   logic [15:0] b;
   logic [2:0]  alu_op;
   logic        en;
   logic [15:0] result;
   logic [3:0]  flags;
   logic        illegal_op;
   logic [15:0] result_q;
   logic [3:0]  flags_q;
   logic        valid_q;

   int testsRun;
   int testsFailed;

   alu dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .a          (a),
      .b          (b),
      .alu_op     (alu_op),
      .en         (en),
      .result     (result),
      .flags      (flags),
      .illegal_op (illegal_op),
      .result_q   (result_q),
      .flags_q    (flags_q),
      .valid_q    (valid_q)
   );

   // Free-running 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input logic [15:0] aIn, input logic [15:0] bIn,
                                input logic [2:0] opIn, input logic enIn);
      a      = aIn;
      b      = bIn;
      alu_op = opIn;
      en     = enIn;
   endtask

   // Compares packed {1-bit, 4-bit flags, 16-bit value} vectors
   task automatic checkOutput(input string tag, input logic [20:0] observed,
                              input logic [20:0] expected);
      testsRun++;
      assert (observed === expected)
      else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Combinational check: {illegal_op, flags, result}
   task automatic checkComb(input string tag, input logic [15:0] aIn, input logic [15:0] bIn,
                            input logic [2:0] opIn, input logic [15:0] expRes,
                            input logic [3:0] expFlags, input logic expIll);
      applyStimulus(aIn, bIn, opIn, 1'b0);
      #1;
      checkOutput(tag, {illegal_op, flags, result}, {expIll, expFlags, expRes});
   endtask

   // Directed sequence; flags are written as {V, C, N, Z}
   initial begin
      testsRun    = 0;
      testsFailed = 0;
      rst_n       = 1'b0;
      applyStimulus(16'h000A, 16'h0002, OP_ADD, 1'b0);
      #2;
      checkOutput("reset_regs", {valid_q, flags_q, result_q}, 21'h0);
      checkOutput("comb_in_reset", {illegal_op, flags, result}, {1'b0, 4'b0000, 16'h000C});

      checkComb("sw_add", 16'h000A, 16'h0002, 3'd0, 16'h000C, 4'b0000, 1'b0);
      checkComb("sw_sub", 16'h000A, 16'h0002, 3'd1, 16'h0008, 4'b0000, 1'b0);
      checkComb("sw_mul", 16'h000A, 16'h0002, 3'd2, 16'h0014, 4'b0000, 1'b0);
      checkComb("sw_rr",  16'h000A, 16'h0002, 3'd3, 16'h0001, 4'b0000, 1'b0);
      checkComb("sw_rl",  16'h000A, 16'h0002, 3'd4, 16'h0004, 4'b0000, 1'b0);
      checkComb("sw_op5", 16'h000A, 16'h0002, 3'd5, 16'h0000, 4'b0001, 1'b1);
      checkComb("sw_op6", 16'h000A, 16'h0002, 3'd6, 16'h0000, 4'b0001, 1'b1);
      checkComb("sw_op7", 16'h000A, 16'h0002, 3'd7, 16'h0000, 4'b0001, 1'b1);

      checkComb("v1_add", 16'h957C, 16'hDE63, 3'd0, 16'h73DF, 4'b1100, 1'b0);
      checkComb("v1_sub", 16'h957C, 16'hDE63, 3'd1, 16'hB719, 4'b0110, 1'b0);
      checkComb("v1_mul", 16'h957C, 16'hDE63, 3'd2, 16'h56F4, 4'b0100, 1'b0);
      checkComb("v1_rr",  16'h957C, 16'hDE63, 3'd3, 16'h6F31, 4'b0100, 1'b0);
      checkComb("v1_rl",  16'h957C, 16'hDE63, 3'd4, 16'hBCC6, 4'b0110, 1'b0);

      checkComb("v2_add", 16'h0000, 16'h0001, 3'd0, 16'h0001, 4'b0000, 1'b0);
      checkComb("v2_sub", 16'h0000, 16'h0001, 3'd1, 16'hFFFF, 4'b0110, 1'b0);
      checkComb("v2_mul", 16'h0000, 16'h0001, 3'd2, 16'h0000, 4'b0001, 1'b0);
      checkComb("v2_rr",  16'h0000, 16'h0001, 3'd3, 16'h0000, 4'b0101, 1'b0);
      checkComb("v2_rl",  16'h0000, 16'h0001, 3'd4, 16'h0002, 4'b0000, 1'b0);

      checkComb("v3_add", 16'h65FA, 16'hF13F, 3'd0, 16'h5739, 4'b0100, 1'b0);
      checkComb("v3_rr",  16'h65FA, 16'hF13F, 3'd3, 16'h789F, 4'b0100, 1'b0);
      checkComb("v3_rl",  16'h65FA, 16'hF13F, 3'd4, 16'hE27E, 4'b0110, 1'b0);

      checkComb("ovf_add", 16'h7FFF, 16'h0001, 3'd0, 16'h8000, 4'b1010, 1'b0);
      checkComb("ovf_sub", 16'h8000, 16'h0001, 3'd1, 16'h7FFF, 4'b1000, 1'b0);

      // Registers stay cleared while reset is held, even with en high across edges
      applyStimulus(16'h957C, 16'hDE63, OP_ADD, 1'b1);
      @(posedge clk); #1;
      checkOutput("held_in_reset", {valid_q, flags_q, result_q}, 21'h0);

      // Release reset away from the edge; first en=1 edge captures
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      checkOutput("cap_v1_add", {valid_q, flags_q, result_q}, {1'b1, 4'b1100, 16'h73DF});

      // Asynchronous reset mid-cycle clears registers without a clock edge
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_reset", {valid_q, flags_q, result_q}, 21'h0);
      checkOutput("comb_during_reset", {illegal_op, flags, result}, {1'b0, 4'b1100, 16'h73DF});

      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(16'h000A, 16'h0002, OP_ADD, 1'b1);
      @(posedge clk); #1;
      checkOutput("post_reset_cap", {valid_q, flags_q, result_q}, {1'b1, 4'b0000, 16'h000C});

      // en dropped with new inputs: registers hold, valid drops, comb follows
      @(negedge clk);
      applyStimulus(16'h0000, 16'h0001, OP_SUB, 1'b0);
      @(posedge clk); #1;
      checkOutput("hold_regs", {valid_q, flags_q, result_q}, {1'b0, 4'b0000, 16'h000C});
      checkOutput("comb_tracks", {illegal_op, flags, result}, {1'b0, 4'b0110, 16'hFFFF});

      // Inputs and en change together; capture uses values present at the edge
      @(negedge clk);
      applyStimulus(16'h957C, 16'hDE63, OP_MUL, 1'b1);
      @(posedge clk); #1;
      checkOutput("cap_mul", {valid_q, flags_q, result_q}, {1'b1, 4'b0100, 16'h56F4});

      // Illegal op captured: zeros with zero flag set
      @(negedge clk);
      applyStimulus(16'h1234, 16'h5678, 3'd6, 1'b1);
      @(posedge clk); #1;
      checkOutput("cap_illegal", {valid_q, flags_q, result_q}, {1'b1, 4'b0001, 16'h0000});

      @(negedge clk);
      en = 1'b0;
      @(posedge clk); #1;
      checkOutput("valid_drop", {valid_q, flags_q, result_q}, {1'b0, 4'b0001, 16'h0000});

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
